// File: rtl/pipe_clk_pkg.sv
// Shared rate codes, FSM state encoding and one-hot clock-select constants for the PIPE PCLK controller.
package pipe_clk_pkg;

  localparam logic [1:0] RATE_GEN1 = 2'd0;
  localparam logic [1:0] RATE_GEN2 = 2'd1;
  localparam logic [1:0] RATE_GEN3 = 2'd2;

  localparam logic [2:0] CLK_SEL_NONE = 3'b000;
  localparam logic [2:0] CLK_SEL_125  = 3'b001;
  localparam logic [2:0] CLK_SEL_250  = 3'b010;
  localparam logic [2:0] CLK_SEL_500  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_QUAL = 2'd1,
    ST_GAP  = 2'd2,
    ST_SEL  = 2'd3
  } pclk_state_e;

  function automatic logic rate_legal(input logic [1:0] code, input logic gen3_en);
    return (code == RATE_GEN1) || (code == RATE_GEN2) || (gen3_en && (code == RATE_GEN3));
  endfunction

  function automatic logic [2:0] rate_onehot(input logic [1:0] code);
    case (code)
      RATE_GEN2: return CLK_SEL_250;
      RATE_GEN3: return CLK_SEL_500;
      default:   return CLK_SEL_125;
    endcase
  endfunction

endpackage

// File: rtl/pipe_pclk_ctrl_if.sv
// Lane rate requests / lock in, clock select and status out; no handshake, all levels.
interface pipe_pclk_ctrl_if #(parameter int LANES = 8);

  logic [2*LANES-1:0] lane_rate_req;
  logic [LANES-1:0]   lane_active;
  logic               mmcm_locked;
  logic [2:0]         clk_sel;
  logic [1:0]         cur_rate;
  logic               switching;
  logic               rate_mismatch;
  logic [15:0]        switch_count;

  modport master (
    output lane_rate_req, lane_active, mmcm_locked,
    input  clk_sel, cur_rate, switching, rate_mismatch, switch_count
  );

  modport slave (
    input  lane_rate_req, lane_active, mmcm_locked,
    output clk_sel, cur_rate, switching, rate_mismatch, switch_count
  );

endinterface

// File: rtl/pipe_pclk_ctrl_sync_bits.sv
// Per-bit flop-chain synchroniser; latency STAGES cycles, no backpressure.
module sync_bits #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE", shreg_extract = "no" *) logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pipe_pclk_ctrl.sv
// PIPE PCLK rate controller: votes lane rate requests, qualifies, then glitch-free switches clk_sel via a gap.
// Latency: SYNC_STAGES + STABLE_CYCLES to gap start, GAP_CYCLES more to new select; no backpressure.
module pipe_pclk_ctrl
  import pipe_clk_pkg::*;
#(
  parameter int LANES         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int GAP_CYCLES    = 4,
  parameter int GEN3_EN       = 0
) (
  input logic              clk,
  input logic              reset,
  pipe_pclk_ctrl_if.slave  bus
);

  localparam logic [7:0] QUAL_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

  logic [2*LANES-1:0] req_s;
  logic               lock_s;

  sync_bits #(.WIDTH(2*LANES), .STAGES(SYNC_STAGES)) u_sync_req (
    .clk   (clk),
    .reset (reset),
    .d     (bus.lane_rate_req),
    .q     (req_s)
  );

  sync_bits #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_lock (
    .clk   (clk),
    .reset (reset),
    .d     (bus.mmcm_locked),
    .q     (lock_s)
  );

  // lane_active is quasi-static, so it feeds the vote without synchronising.
  logic [1:0] vote_code;
  logic       vote_any;
  logic       vote_diff;
  logic       vote_ok;

  always_comb begin
    vote_code = RATE_GEN1;
    vote_any  = 1'b0;
    vote_diff = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.lane_active[i]) begin
        if (!vote_any) vote_code = req_s[2*i +: 2];
        else if (req_s[2*i +: 2] != vote_code) vote_diff = 1'b1;
        vote_any = 1'b1;
      end
    end
    vote_ok = vote_any && !vote_diff && rate_legal(vote_code, GEN3_EN != 0);
  end

  pclk_state_e state_q;
  logic [7:0]  qual_cnt_q;
  logic [3:0]  gap_cnt_q;
  logic [1:0]  target_q;
  logic [2:0]  clk_sel_q;
  logic [1:0]  cur_rate_q;
  logic        switching_q;
  logic        mismatch_q;
  logic [15:0] switch_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      qual_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      target_q       <= RATE_GEN1;
      clk_sel_q      <= CLK_SEL_125;
      cur_rate_q     <= RATE_GEN1;
      switching_q    <= 1'b0;
      mismatch_q     <= 1'b0;
      switch_count_q <= '0;
    end else begin
      mismatch_q <= vote_diff;
      case (state_q)
        ST_IDLE: begin
          if (vote_ok && (vote_code != cur_rate_q) && lock_s) begin
            target_q   <= vote_code;
            qual_cnt_q <= 8'd1;
            state_q    <= ST_QUAL;
          end
        end
        ST_QUAL: begin
          if (!vote_ok || (vote_code != target_q) || !lock_s) begin
            state_q <= ST_IDLE;
          end else if (qual_cnt_q >= QUAL_LAST) begin
            state_q     <= ST_GAP;
            gap_cnt_q   <= '0;
            clk_sel_q   <= CLK_SEL_NONE;
            switching_q <= 1'b1;
          end else begin
            qual_cnt_q <= qual_cnt_q + 8'd1;
          end
        end
        ST_GAP: begin
          // Losing lock mid-gap falls back to the safe 125 MHz buffer.
          if (!lock_s) begin
            clk_sel_q   <= CLK_SEL_125;
            cur_rate_q  <= RATE_GEN1;
            switching_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (gap_cnt_q == GAP_LAST) begin
            clk_sel_q   <= rate_onehot(target_q);
            cur_rate_q  <= target_q;
            switching_q <= 1'b0;
            state_q     <= ST_SEL;
            if (switch_count_q != 16'hFFFF) switch_count_q <= switch_count_q + 16'd1;
          end else begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end
        ST_SEL:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.clk_sel       = clk_sel_q;
  assign bus.cur_rate      = cur_rate_q;
  assign bus.switching     = switching_q;
  assign bus.rate_mismatch = mismatch_q;
  assign bus.switch_count  = switch_count_q;

endmodule

// File: tb/tb_pipe_pclk_ctrl.sv
// Directed bench for pipe_pclk_ctrl: instance A with Gen3 disabled, instance B with Gen3 enabled, shared stimulus.
module tb_pipe_pclk_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] req;
  logic [7:0]  act;
  logic        lock;
  logic        bad;

  int checks;
  int errors;

  pipe_pclk_ctrl_if #(.LANES(8)) ia ();
  pipe_pclk_ctrl_if #(.LANES(8)) ib ();

  assign ia.lane_rate_req = req;
  assign ia.lane_active   = act;
  assign ia.mmcm_locked   = lock;
  assign ib.lane_rate_req = req;
  assign ib.lane_active   = act;
  assign ib.mmcm_locked   = lock;

  pipe_pclk_ctrl #(.LANES(8), .SYNC_STAGES(2), .STABLE_CYCLES(16), .GAP_CYCLES(4), .GEN3_EN(0)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ia)
  );

  pipe_pclk_ctrl #(.LANES(8), .SYNC_STAGES(2), .STABLE_CYCLES(16), .GAP_CYCLES(4), .GEN3_EN(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    req    = 16'h0000;
    act    = 8'hFF;
    lock   = 1'b1;
    bad    = 1'b0;

    // Reset values
    tick(3);
    check("rst_a_clk_sel",  32'(ia.clk_sel), 32'h1);
    check("rst_a_cur_rate", 32'(ia.cur_rate), 32'h0);
    check("rst_a_switching", 32'(ia.switching), 32'h0);
    check("rst_a_mismatch", 32'(ia.rate_mismatch), 32'h0);
    check("rst_a_count",    32'(ia.switch_count), 32'h0);
    check("rst_b_clk_sel",  32'(ib.clk_sel), 32'h1);
    reset = 1'b0;
    tick(5);

    // Short request burst must not reach the gap
    req = 16'h5555;
    tick(10);
    req = 16'h0000;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (ia.clk_sel !== 3'b001) bad = 1'b1;
    end
    check("glitch_sel_held", 32'(bad), 32'h0);
    check("glitch_count",    32'(ia.switch_count), 32'h0);

    // Clean switch to Gen2: gap starts 18 edges after the request edge
    req = 16'h5555;
    tick(17);
    check("pre_gap_sel",     32'(ia.clk_sel), 32'h1);
    check("pre_gap_sw",      32'(ia.switching), 32'h0);
    tick(1);
    check("gap_start_sel",   32'(ia.clk_sel), 32'h0);
    check("gap_start_sw",    32'(ia.switching), 32'h1);
    tick(3);
    check("gap_end_sel",     32'(ia.clk_sel), 32'h0);
    tick(1);
    check("gen2_sel",        32'(ia.clk_sel), 32'h2);
    check("gen2_cur_rate",   32'(ia.cur_rate), 32'h1);
    check("gen2_count",      32'(ia.switch_count), 32'h1);
    check("gen2_sw",         32'(ia.switching), 32'h0);
    check("gen2_mismatch",   32'(ia.rate_mismatch), 32'h0);

    // Gen3 request: illegal on A, legal on B
    req = 16'hAAAA;
    tick(40);
    check("gen3off_sel",     32'(ia.clk_sel), 32'h2);
    check("gen3off_rate",    32'(ia.cur_rate), 32'h1);
    check("gen3off_count",   32'(ia.switch_count), 32'h1);
    check("gen3on_sel",      32'(ib.clk_sel), 32'h4);
    check("gen3on_rate",     32'(ib.cur_rate), 32'h2);
    check("gen3on_count",    32'(ib.switch_count), 32'h2);

    // B switches 2->1, lock lost in the gap; A already at rate 1 ignores it
    req = 16'h5555;
    tick(18);
    check("lockgap_b_sel",   32'(ib.clk_sel), 32'h0);
    check("lockgap_b_sw",    32'(ib.switching), 32'h1);
    check("lockgap_a_sel",   32'(ia.clk_sel), 32'h2);
    lock = 1'b0;
    tick(3);
    check("lockloss_sel",    32'(ib.clk_sel), 32'h1);
    check("lockloss_rate",   32'(ib.cur_rate), 32'h0);
    check("lockloss_count",  32'(ib.switch_count), 32'h2);
    check("lockloss_sw",     32'(ib.switching), 32'h0);
    tick(10);
    check("nolock_hold_sel", 32'(ib.clk_sel), 32'h1);

    // Relock puts B into qualification; reset there clears everything next edge
    lock = 1'b1;
    tick(6);
    reset = 1'b1;
    tick(1);
    check("rstq_b_sel",      32'(ib.clk_sel), 32'h1);
    check("rstq_b_rate",     32'(ib.cur_rate), 32'h0);
    check("rstq_b_sw",       32'(ib.switching), 32'h0);
    check("rstq_b_count",    32'(ib.switch_count), 32'h0);
    check("rstq_a_sel",      32'(ia.clk_sel), 32'h1);
    check("rstq_a_count",    32'(ia.switch_count), 32'h0);
    req = 16'h1555;
    tick(2);
    reset = 1'b0;

    // Lane 7 disagrees: mismatch, no switch until it is deactivated
    tick(30);
    check("mm_flag",         32'(ia.rate_mismatch), 32'h1);
    check("mm_sel_held",     32'(ia.clk_sel), 32'h1);
    check("mm_count",        32'(ia.switch_count), 32'h0);
    act = 8'h7F;
    tick(1);
    check("mm_cleared",      32'(ia.rate_mismatch), 32'h0);
    tick(24);
    check("mm_switch_sel",   32'(ia.clk_sel), 32'h2);
    check("mm_switch_rate",  32'(ia.cur_rate), 32'h1);
    check("mm_switch_count", 32'(ia.switch_count), 32'h1);

    // Saturation from a preloaded count
    force dut_a.switch_count_q = 16'hFFFE;
    #1;
    release dut_a.switch_count_q;
    req = 16'h0000;
    tick(30);
    check("sat_sel_gen1",    32'(ia.clk_sel), 32'h1);
    check("sat_count_max",   32'(ia.switch_count), 32'hFFFF);
    req = 16'h5555;
    tick(30);
    check("sat_sel_gen2",    32'(ia.clk_sel), 32'h2);
    check("sat_count_hold",  32'(ia.switch_count), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
